// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller between the EX/MEM and MEM/WB pipeline
// registers.
//   Non-memory instructions go straight to the MEM/WB fields with one cycle of
//   latency. A load or store is captured into local latches, and the block
//   then runs a req/ready handshake with the data memory. While that access is
//   outstanding, stall freezes the upstream stages.
//
// Optional feature: define MEM_TIMEOUT_EN to add an 8-bit wait counter.
//   An access that waits TIMEOUT cycles without mem_ready is abandoned.
//   The abandoned access sets the sticky mem_err flag.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   EXMEM_*             EX/MEM register outputs (result, store data, opcode,
//                       dest reg, address, valid, flags)
//   mem_req/we/addr/wdata  data-memory request (valid only while in ACCESS)
//   mem_ready/rdata     data-memory completion and load data
//   stall               combinational freeze of PC/IFID/IDEX/EXMEM
//   MEMWB_*             registered MEM/WB fields plus register-file write enable
//   mem_err             sticky timeout flag (always 0 without MEM_TIMEOUT_EN)
module mem_stage_ctrl #(
    parameter logic [3:0] LD_OPCODE = 4'hC,
    parameter logic [3:0] ST_OPCODE = 4'hD,
    parameter int         TIMEOUT   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] EXMEM_result,
    input  logic [7:0] EXMEM_operand_b,
    input  logic [3:0] EXMEM_opcode,
    input  logic [1:0] EXMEM_ra,
    input  logic [7:0] EXMEM_address,
    input  logic       EXMEM_valid,
    input  logic [3:0] EXMEM_flags,
    input  logic       mem_ready,
    input  logic [7:0] mem_rdata,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       stall,
    output logic [7:0] MEMWB_result,
    output logic [3:0] MEMWB_opcode,
    output logic [1:0] MEMWB_ra,
    output logic [3:0] MEMWB_flags,
    output logic       MEMWB_valid,
    output logic       MEMWB_wb_en,
    output logic       mem_err
);

    // The wait counter is 8 bits wide, so TIMEOUT must stay in 1..256.
    if (TIMEOUT < 1 || TIMEOUT > 256) begin : g_bad_timeout
        $error("mem_stage_ctrl: TIMEOUT out of range");
    end

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [3:0] op_q, op_d;
    logic [1:0] ra_q, ra_d;
    logic [3:0] flags_q, flags_d;
    logic       we_q, we_d;
    logic [7:0] wb_result_q, wb_result_d;
    logic [3:0] wb_opcode_q, wb_opcode_d;
    logic [1:0] wb_ra_q, wb_ra_d;
    logic [3:0] wb_flags_q, wb_flags_d;
    logic       wb_valid_q, wb_valid_d;
    logic       wb_en_q, wb_en_d;
    logic       memop, timeout;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`endif

    assign memop = EXMEM_valid &&
                   (EXMEM_opcode == LD_OPCODE || EXMEM_opcode == ST_OPCODE);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        op_d        = op_q;
        ra_d        = ra_q;
        flags_d     = flags_q;
        we_d        = we_q;
        wb_result_d = wb_result_q;
        wb_opcode_d = wb_opcode_q;
        wb_ra_d     = wb_ra_q;
        wb_flags_d  = wb_flags_q;
        wb_valid_d  = wb_valid_q;
        wb_en_d     = wb_en_q;
        timeout     = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (memop) begin
                    addr_d     = EXMEM_address;
                    wdata_d    = EXMEM_operand_b;
                    op_d       = EXMEM_opcode;
                    ra_d       = EXMEM_ra;
                    flags_d    = EXMEM_flags;
                    we_d       = (EXMEM_opcode == ST_OPCODE);
                    wb_valid_d = 1'b0;
                    wb_en_d    = 1'b0;
                    state_d    = ACCESS;
`ifdef MEM_TIMEOUT_EN
                    cnt_d      = 8'd0;
`endif
                end else begin
                    // Pass-through; an invalid input becomes a bubble.
                    wb_result_d = EXMEM_result;
                    wb_opcode_d = EXMEM_opcode;
                    wb_ra_d     = EXMEM_ra;
                    wb_flags_d  = EXMEM_flags;
                    wb_valid_d  = EXMEM_valid;
                    wb_en_d     = EXMEM_valid;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    wb_result_d = we_q ? wdata_q : mem_rdata;
                    wb_opcode_d = op_q;
                    wb_ra_d     = ra_q;
                    wb_flags_d  = flags_q;
                    wb_valid_d  = 1'b1;
                    wb_en_d     = !we_q;
                    state_d     = IDLE;
                end else begin
                    wb_valid_d  = 1'b0;
                    wb_en_d     = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    if (cnt_q == CNT_LAST) begin
                        // Give up: retire the access with a zero result and
                        // no register write, so the pipeline can proceed.
                        timeout     = 1'b1;
                        wb_result_d = 8'h00;
                        wb_opcode_d = op_q;
                        wb_ra_d     = ra_q;
                        wb_flags_d  = flags_q;
                        wb_valid_d  = 1'b1;
                        err_d       = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            op_q        <= '0;
            ra_q        <= '0;
            flags_q     <= '0;
            we_q        <= 1'b0;
            wb_result_q <= '0;
            wb_opcode_q <= '0;
            wb_ra_q     <= '0;
            wb_flags_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_en_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            op_q        <= op_d;
            ra_q        <= ra_d;
            flags_q     <= flags_d;
            we_q        <= we_d;
            wb_result_q <= wb_result_d;
            wb_opcode_q <= wb_opcode_d;
            wb_ra_q     <= wb_ra_d;
            wb_flags_q  <= wb_flags_d;
            wb_valid_q  <= wb_valid_d;
            wb_en_q     <= wb_en_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    // The request is a pure decode of the state, so a reset that lands during
    // ACCESS removes it at that very edge.
    assign mem_req   = (state_q == ACCESS);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = mem_req ? addr_q  : 8'h00;
    assign mem_wdata = mem_req ? wdata_q : 8'h00;
    assign stall     = (state_q == IDLE && memop) ||
                       (state_q == ACCESS && !mem_ready && !timeout);

    assign MEMWB_result = wb_result_q;
    assign MEMWB_opcode = wb_opcode_q;
    assign MEMWB_ra     = wb_ra_q;
    assign MEMWB_flags  = wb_flags_q;
    assign MEMWB_valid  = wb_valid_q;
    assign MEMWB_wb_en  = wb_en_q;

`ifdef MEM_TIMEOUT_EN
    assign mem_err = err_q;
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Passes non-memory instructions to the MEM/WB register in one cycle.
- Runs a request/ready handshake to the data memory for LD/ST, stalling upstream stages until the memory responds.
- Drives the MEM/WB register fields directly as registered outputs.

Parameters:
- LD_OPCODE, 4'hC, opcode treated as load
- ST_OPCODE, 4'hD, opcode treated as store
- TIMEOUT, 16, max wait cycles in ACCESS (only used with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- EXMEM_result  in  8  ALU result
- EXMEM_operand_b  in  8  store data
- EXMEM_opcode  in  4  opcode
- EXMEM_ra  in  2  destination register
- EXMEM_address  in  8  memory address for LD/ST
- EXMEM_valid  in  1  instruction valid
- EXMEM_flags  in  4  ALU flags
- mem_ready  in  1  data memory completes access this cycle
- mem_rdata  in  8  load data, valid when mem_ready=1
- mem_req  out  1  access request (high for the whole ACCESS state)
- mem_we  out  1  1=store, 0=load
- mem_addr  out  8  latched address
- mem_wdata  out  8  latched store data
- stall  out  1  combinational; freezes PC/IFID/IDEX/EXMEM
- MEMWB_result  out  8  ALU result or load data
- MEMWB_opcode  out  4
- MEMWB_ra  out  2
- MEMWB_flags  out  4
- MEMWB_valid  out  1
- MEMWB_wb_en  out  1  register-file write enable
- mem_err  out  1  sticky timeout flag (MEM_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
- Reset: the block synchronously returns to IDLE. It clears MEMWB_* outputs, mem_req, mem_we, mem_addr, mem_wdata, mem_err and the wait counter. Reset during ACCESS drops mem_req at the same edge, with no completion and no writeback.
- memop = EXMEM_valid && (EXMEM_opcode==LD_OPCODE || EXMEM_opcode==ST_OPCODE).
- stall = (state==IDLE && memop) || (state==ACCESS && !mem_ready).
- State IDLE:
  - If !memop: MEMWB_* <= EXMEM_* on every clock, giving 1-cycle latency.
  - MEMWB_valid <= EXMEM_valid; MEMWB_wb_en <= EXMEM_valid.
  - An invalid input produces a bubble with valid=0 and wb_en=0.
  - If memop: latch address, operand_b, opcode, ra, flags and mem_we (=ST) into internal regs, go to ACCESS, and write a bubble to MEMWB (valid=0, wb_en=0).
- State ACCESS:
  - Outputs: mem_req=1, mem_we/addr/wdata from latches.
  - If mem_ready, at that edge:
    - MEMWB_valid <= 1.
    - MEMWB_result <= mem_rdata for LD, latched operand_b for ST.
    - MEMWB_wb_en <= 1 for LD, 0 for ST.
    - MEMWB_ra/opcode/flags come from the latches.
    - Return to IDLE.
  - stall is low in the mem_ready cycle, so EXMEM advances at the same edge. The next instruction is evaluated in IDLE on the following cycle, and back-to-back memops each re-enter ACCESS.
  - If !mem_ready, hold all latches, MEMWB_valid <= 0, stay.
- Minimum memop occupancy is 2 cycles: IDLE detect, then ACCESS with mem_ready=1. Each extra wait cycle adds 1.
- Inputs EXMEM_* are ignored while in ACCESS; the latched copies are authoritative.
- mem_rdata is sampled only when state==ACCESS && mem_ready && !mem_we.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- When defined:
  - An 8-bit wait counter clears on ACCESS entry and increments each ACCESS cycle without mem_ready.
  - When it reaches TIMEOUT-1 with mem_ready still low: drop mem_req, set mem_err (sticky until reset), and write MEMWB with valid=1, wb_en=0, result=8'h00. Return to IDLE; stall is low that cycle.
- When undefined: no counter, ACCESS waits indefinitely, mem_err is constant 0.

Test Plan:
1. ADD-class opcode 4'h1, valid=1, result=8'h5A, ra=2 -> next cycle MEMWB_result=8'h5A, MEMWB_ra=2, valid=1, wb_en=1, stall=0 throughout.
2. LD addr=8'h20, memory returns 8'h77 with mem_ready on the first ACCESS cycle -> stall high 1 cycle; mem_req=1, mem_we=0, mem_addr=8'h20 for 1 cycle; then MEMWB_result=8'h77, wb_en=1.
3. ST addr=8'h31, operand_b=8'hA5, mem_ready after 3 wait cycles -> mem_we=1, mem_wdata=8'hA5 held 4 cycles; stall high 4 cycles; MEMWB valid=1, wb_en=0.
4. Back-to-back LD, LD, then ADD with mem_ready=1 always -> each LD produces one bubble then its data, and the ADD writes back 1 cycle after the second LD completes; no instruction is lost or duplicated.
5. Reset asserted on the 2nd ACCESS cycle of an LD -> next cycle mem_req=0, MEMWB_valid=0, state IDLE; a later mem_ready pulse has no effect.
6. With MEM_TIMEOUT_EN and TIMEOUT=16, LD with mem_ready held 0 -> mem_req drops after 16 ACCESS cycles, mem_err=1, MEMWB valid=1, wb_en=0, result=8'h00.
